// File: rtl/debounce_multi_counter.sv
// debounce_multi_counter
//   Multi-channel switch debouncer with press and bounce statistics.
//   Each channel has a 2-flop synchroniser, a ZERO/WAIT1/ONE/WAIT0 debounce
//   FSMD, a debounced-press counter and a raw-rising-edge (bounce) counter.
//   A registered channel-select mux feeds the display.
//
//   Build option: define DEBOUNCE_CNT_SAT_EN to make both counters saturate
//   at all-ones instead of wrapping.
//
// Ports
//   clk       : system clock
//   reset     : synchronous, active-high
//   sw        : raw asynchronous switch levels (active-high), one per channel
//   clr       : per-channel synchronous clear of both counters
//   sel       : channel shown on press_cnt/raw_cnt (out of range -> channel 0)
//   db_level  : debounced level per channel
//   db_tick   : one-cycle pulse per debounced press, per channel
//   press_cnt : registered press count of the selected channel
//   raw_cnt   : registered raw-edge count of the selected channel
module debounce_multi_counter #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 500000,
  localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  sw,
  input  logic [N_CH-1:0]  clr,
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  db_level,
  output logic [N_CH-1:0]  db_tick,
  output logic [CNT_W-1:0] press_cnt,
  output logic [CNT_W-1:0] raw_cnt
);

  localparam int STAB_W = $clog2(DB_CYCLES);
  // Window ends when the counter reaches DB_CYCLES-2: one cycle is spent
  // entering WAITx and one more registering the transition.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DB_CYCLES - 2);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef DEBOUNCE_CNT_SAT_EN
    return (c == '1) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  s_d;
  logic [N_CH-1:0]  raw_edge;
  logic [CNT_W-1:0] press_arr [N_CH];
  logic [CNT_W-1:0] raw_arr   [N_CH];
  logic [CNT_W-1:0] press_sel;
  logic [CNT_W-1:0] raw_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
      s_d   <= '0;
    end else begin
      sync1 <= sw;
      s     <= sync1;
      s_d   <= s;
    end
  end

  always_comb raw_edge = s & ~s_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    db_state_t         state_q, state_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              tick_q, tick_d;
    logic              level_c;
    logic [CNT_W-1:0]  press_q, raw_q;

    // State register
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ZERO;
        stab_q  <= '0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        stab_q  <= stab_d;
        tick_q  <= tick_d;
      end
    end

    // Next-state logic
    always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      tick_d  = 1'b0;
      unique case (state_q)
        ZERO: if (s[g]) begin
          state_d = WAIT1;
          stab_d  = '0;
        end
        WAIT1: begin
          if (!s[g]) begin
            state_d = ZERO;
          end else if (stab_q == STAB_LAST) begin
            state_d = ONE;
            tick_d  = 1'b1;
          end else begin
            stab_d = stab_q + STAB_W'(1);
          end
        end
        ONE: if (!s[g]) begin
          state_d = WAIT0;
          stab_d  = '0;
        end
        WAIT0: begin
          if (s[g]) begin
            state_d = ONE;
          end else if (stab_q == STAB_LAST) begin
            state_d = ZERO;
          end else begin
            stab_d = stab_q + STAB_W'(1);
          end
        end
        default: state_d = ZERO;
      endcase
    end

    // Output decode
    always_comb begin
      level_c = (state_q == ONE) || (state_q == WAIT0);
    end

    assign db_level[g] = level_c;
    assign db_tick[g]  = tick_q;

    // Clear has priority over a same-cycle increment
    always_ff @(posedge clk) begin
      if (reset || clr[g]) begin
        press_q <= '0;
        raw_q   <= '0;
      end else begin
        if (tick_q)      press_q <= bump(press_q);
        if (raw_edge[g]) raw_q   <= bump(raw_q);
      end
    end

    assign press_arr[g] = press_q;
    assign raw_arr[g]   = raw_q;
  end

  // Out-of-range sel falls through to the channel 0 default
  always_comb begin
    press_sel = press_arr[0];
    raw_sel   = raw_arr[0];
    for (int unsigned i = 1; i < N_CH; i++) begin
      if (32'(sel) == i) begin
        press_sel = press_arr[i];
        raw_sel   = raw_arr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_cnt <= '0;
      raw_cnt   <= '0;
    end else begin
      press_cnt <= press_sel;
      raw_cnt   <= raw_sel;
    end
  end

endmodule
